sparse_frame_packer: RTL
========================

SPARSE_FRAME_PACKER -- requirements
Module: sparse_frame_packer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter LANES, default 9, SHALL set the lanes per frame (fixed at 9 for this design).
REQ-003 Parameter W, default 8, SHALL set the data and index width.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: an input pair is offered.
REQ-007 Port in_ready, output, 1 bit: the block can accept a pair.
REQ-008 Port in_data, input, 8 bits: pair value.
REQ-009 Port in_index, input, 8 bits: pair bin index; legal range 0..8.
REQ-010 Port in_last, input, 1 bit: this pair closes the current frame.
REQ-011 Port frame_valid, output, 1 bit: a packed frame is presented.
REQ-012 Port frame_ready, input, 1 bit: downstream reorder-and-add consumes the frame.
REQ-013 Ports data_out0..data_out8, output, 8 bits each: packed lane values, feeding data_in0..8 downstream.
REQ-014 Ports index_out0..index_out8, output, 8 bits each: packed lane indices, feeding index0..8 downstream.
REQ-015 Port frame_lanes, output, 4 bits: number of real lanes in the presented frame.
REQ-016 Port err_oor, output, 1 bit: sticky flag, set when an out-of-range index has been dropped.

Function
REQ-017 The block SHALL be an FSM with two states, FILL and HOLD; FILL is the reset state.
REQ-018 A pair SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1.
REQ-019 In FILL, in_ready SHALL be 1 and frame_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and frame_valid SHALL be 1.
REQ-020 An accepted pair with in_index<=8 SHALL be written to lane[cnt] (data and index), and the 4-bit lane counter cnt SHALL then increment.
REQ-021 An accepted pair with in_index>8 SHALL be dropped: no lane is written, cnt is unchanged, and err_oor is set to 1 and held until reset.
REQ-022 FILL SHALL go to HOLD on the edge that accepts the 9th legal pair (cnt reaches 9), with or without in_last.
REQ-023 FILL SHALL go to HOLD on the edge that accepts a pair with in_last=1, provided the resulting cnt>=1.
REQ-024 A pair with in_last=1 that leaves cnt=0 (a dropped pair with an empty frame) SHALL emit no frame; the block SHALL stay in FILL.
REQ-025 Latency: frame_valid SHALL rise in the cycle immediately after the closing accept edge.
REQ-026 Unfilled lanes (index >= cnt) SHALL present data_out=0 and index_out=0, so that they add 0 to bin 0 downstream.
REQ-027 In HOLD, all data_out, index_out and frame_lanes SHALL remain stable until the frame is consumed.
REQ-028 frame_lanes SHALL equal cnt while in HOLD and SHALL read 0 while in FILL.
REQ-029 A HOLD-state edge with frame_ready=1 SHALL return the FSM to FILL, zero all lanes, and clear cnt.
REQ-030 There is no input/output overlap: a pair offered in the cycle the frame is consumed SHALL be accepted only on the following edge.
REQ-031 frame_ready SHALL be ignored in FILL.
REQ-032 in_data and in_index SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-033 Assertion of rst_n=0 SHALL immediately return the FSM to FILL, including mid-fill or mid-hold.
REQ-034 Reset SHALL clear cnt, all lanes, frame_lanes and err_oor to 0.
REQ-035 In reset, in_ready SHALL be 0 and frame_valid SHALL be 0; in_ready rises in the first cycle after rst_n deasserts.

Verification
REQ-036 Short frame: pairs (0,0) (2,1) (4,2) (8,1), last on the 4th -> next cycle frame_valid=1, data_out0..3=0,2,4,8, index_out0..3=0,1,2,1, lanes 4..8 all 0, frame_lanes=4.
REQ-037 Full frame: nine pairs (k+1,k) for k=0..8, no in_last -> frame_valid after the 9th accept, in_ready=0, data_out8=9, index_out8=8, frame_lanes=9.
REQ-038 Backpressure: hold frame_ready=0 for 5 cycles in HOLD -> outputs unchanged, in_ready=0; on frame_ready=1 -> next cycle FILL, frame_valid=0, all lanes 0.
REQ-039 Out-of-range: pairs (5,9) then (7,3) with last -> err_oor=1 from the cycle after the first accept; frame has data_out0=7, index_out0=3, frame_lanes=1.
REQ-040 Empty flush: a single pair (5,12) with last -> no frame_valid, FSM stays in FILL, err_oor=1.
REQ-041 Reset mid-fill: 3 pairs accepted, then rst_n=0 -> all outputs 0, err_oor=0; the next frame starts at lane 0.

Source files
------------

// File: rtl/sparse_frame_packer_if.sv
// Pair-input and packed-frame bus of the sparse frame packer.
// The slave modport is the packer's view; master is the surrounding environment.
interface sparse_frame_packer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] in_index;
  logic         in_last;

  logic         frame_valid;
  logic         frame_ready;
  logic [W-1:0] data_out0, data_out1, data_out2, data_out3, data_out4;
  logic [W-1:0] data_out5, data_out6, data_out7, data_out8;
  logic [W-1:0] index_out0, index_out1, index_out2, index_out3, index_out4;
  logic [W-1:0] index_out5, index_out6, index_out7, index_out8;
  logic [3:0]   frame_lanes;
  logic         err_oor;

  modport slave (
    input  in_valid, in_data, in_index, in_last, frame_ready,
    output in_ready, frame_valid,
    output data_out0, data_out1, data_out2, data_out3, data_out4,
    output data_out5, data_out6, data_out7, data_out8,
    output index_out0, index_out1, index_out2, index_out3, index_out4,
    output index_out5, index_out6, index_out7, index_out8,
    output frame_lanes, err_oor
  );

  modport master (
    output in_valid, in_data, in_index, in_last, frame_ready,
    input  in_ready, frame_valid,
    input  data_out0, data_out1, data_out2, data_out3, data_out4,
    input  data_out5, data_out6, data_out7, data_out8,
    input  index_out0, index_out1, index_out2, index_out3, index_out4,
    input  index_out5, index_out6, index_out7, index_out8,
    input  frame_lanes, err_oor
  );
endinterface

// File: rtl/sparse_frame_packer.sv
// Packs a stream of (value, bin index) pairs into a fixed 9-lane frame for a
// downstream reorder-and-add; unused lanes read (0,0) so they add nothing.
module sparse_frame_packer #(
  parameter int LANES = 9,
  parameter int W     = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  sparse_frame_packer_if.slave bus
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [3:0]   LAST_LANE = 4'(LANES - 1);
  localparam logic [W-1:0] MAX_INDEX = W'(LANES - 1);

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic [3:0]   cnt_after;
  logic [W-1:0] lane_data  [LANES];
  logic [W-1:0] lane_index [LANES];
  logic         armed;
  logic         err_q;
  logic         in_ready_c;
  logic         frame_valid_c;
  logic [3:0]   frame_lanes_c;
  logic         accept;
  logic         legal;
  logic         close;
  logic         consume;

  assign accept    = bus.in_valid && in_ready_c;
  assign legal     = (bus.in_index <= MAX_INDEX);
  assign cnt_after = cnt + {3'b000, legal};
  // A frame closes when the last lane fills, or on in_last if at least one lane holds data.
  assign close     = accept && ((legal && cnt == LAST_LANE) || (bus.in_last && cnt_after != 4'd0));
  assign consume   = (state == HOLD) && bus.frame_ready;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // NOTE: every combinational output is given a default first, so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (close)           state_next = HOLD;
      HOLD:    if (bus.frame_ready) state_next = FILL;
      default:                      state_next = FILL;
    endcase
  end

  // armed keeps in_ready low while in reset and for the edge that releases it.
  always_comb begin
    in_ready_c    = 1'b0;
    frame_valid_c = 1'b0;
    frame_lanes_c = 4'd0;
    case (state)
      FILL: in_ready_c = armed;
      HOLD: begin
        frame_valid_c = 1'b1;
        frame_lanes_c = cnt;
      end
      default: ;
    endcase
  end

  // NOTE: the lane storage is only 9 entries and must read zero straight out of
  // reset, so it is reset like ordinary flops rather than treated as a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      err_q <= 1'b0;
      cnt   <= 4'd0;
      for (int i = 0; i < LANES; i++) begin
        lane_data[i]  <= '0;
        lane_index[i] <= '0;
      end
    end else begin
      armed <= 1'b1;
      if (consume) begin
        cnt <= 4'd0;
        for (int i = 0; i < LANES; i++) begin
          lane_data[i]  <= '0;
          lane_index[i] <= '0;
        end
      end else if (accept) begin
        if (legal) begin
          for (int i = 0; i < LANES; i++) begin
            if (cnt == 4'(i)) begin
              lane_data[i]  <= bus.in_data;
              lane_index[i] <= bus.in_index;
            end
          end
          cnt <= cnt_after;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.frame_valid = frame_valid_c;
  assign bus.frame_lanes = frame_lanes_c;
  assign bus.err_oor     = err_q;

  assign bus.data_out0 = lane_data[0];
  assign bus.data_out1 = lane_data[1];
  assign bus.data_out2 = lane_data[2];
  assign bus.data_out3 = lane_data[3];
  assign bus.data_out4 = lane_data[4];
  assign bus.data_out5 = lane_data[5];
  assign bus.data_out6 = lane_data[6];
  assign bus.data_out7 = lane_data[7];
  assign bus.data_out8 = lane_data[8];

  assign bus.index_out0 = lane_index[0];
  assign bus.index_out1 = lane_index[1];
  assign bus.index_out2 = lane_index[2];
  assign bus.index_out3 = lane_index[3];
  assign bus.index_out4 = lane_index[4];
  assign bus.index_out5 = lane_index[5];
  assign bus.index_out6 = lane_index[6];
  assign bus.index_out7 = lane_index[7];
  assign bus.index_out8 = lane_index[8];

  // A held frame never changes size until consumed, and never holds zero lanes.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state == HOLD && !bus.frame_ready) |=> (state == HOLD && $stable(cnt)));
  a_hold_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    (state == HOLD) |-> (cnt != 4'd0));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= 4'(LANES));

endmodule
